// File: rtl/locked_counter_pkg.sv
// Shared defaults and the key-mismatch to output-mask expansion for locked_counter_v2.
package locked_counter_pkg;

  localparam int          LC_WIDTH    = 8;
  localparam int          LC_KEY_SIZE = 16;
  localparam int          LC_CHUNK    = 4;
  localparam logic [15:0] LC_KEY_GOLD = 16'hA5C3;

  // Upper bounds for the fixed-width mask helper; callers slice the low WIDTH bits.
  localparam int LC_MAX_WIDTH = 32;
  localparam int LC_MAX_KEY   = 256;
  localparam int LC_KEY_IDX_W = $clog2(LC_MAX_KEY);

  // mask[i] = mismatch[i % key_size]; a short key repeats across a wide counter.
  function automatic logic [LC_MAX_WIDTH-1:0] lc_expand_mask(
    input logic [LC_MAX_KEY-1:0] mismatch,
    input int unsigned           key_size
  );
    logic [LC_MAX_WIDTH-1:0] mask;
    logic [LC_KEY_IDX_W-1:0] idx;
    mask = '0;
    for (int i = LC_MAX_WIDTH - 1; i >= 0; i--) begin
      idx  = LC_KEY_IDX_W'(32'(i) % key_size);
      mask = {mask[LC_MAX_WIDTH-2:0], mismatch[idx]};
    end
    return mask;
  endfunction

endpackage

// File: rtl/lc_key_loader.sv
// Chunked serial shadow key with guarded commit into the active key.
// A commit is accepted only once a full key's worth of beats has arrived since the last commit/reset.
module lc_key_loader
  import locked_counter_pkg::*;
#(
  parameter int KEY_SIZE = LC_KEY_SIZE,
  parameter int CHUNK    = LC_CHUNK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_chunk_valid,
  input  logic [CHUNK-1:0]    key_chunk,
  input  logic                key_commit,
  output logic                commit_ack,
  output logic [KEY_SIZE-1:0] active_key
);

  localparam int NCH   = KEY_SIZE / CHUNK;
  localparam int CNT_W = $clog2(NCH + 1);
  localparam logic [CNT_W-1:0] NCH_C = CNT_W'(NCH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [KEY_SIZE-1:0] shadow;
  logic [KEY_SIZE-1:0] shadow_shift;
  logic [KEY_SIZE-1:0] shadow_next;
  logic [CNT_W-1:0]    chunk_cnt;
  logic [CNT_W-1:0]    chunk_cnt_next;
  logic                accept;

  generate
    if (KEY_SIZE == CHUNK) begin : g_single_beat
      assign shadow_shift = key_chunk;
    end else begin : g_multi_beat
      assign shadow_shift = {shadow[KEY_SIZE-CHUNK-1:0], key_chunk};
    end
  endgenerate

  // The commit qualifier looks at the post-shift state so a beat and a commit may share a cycle.
  always_comb begin
    shadow_next    = shadow;
    chunk_cnt_next = chunk_cnt;
    if (key_chunk_valid) begin
      shadow_next = shadow_shift;
      if (chunk_cnt != NCH_C) begin
        chunk_cnt_next = chunk_cnt + ONE_C;
      end
    end
    accept = key_commit && (chunk_cnt_next == NCH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      chunk_cnt  <= '0;
      active_key <= '0;
      commit_ack <= 1'b0;
    end else begin
      shadow     <= shadow_next;
      commit_ack <= accept;
      if (accept) begin
        active_key <= shadow_next;
        chunk_cnt  <= '0;
      end else begin
        chunk_cnt  <= chunk_cnt_next;
      end
    end
  end

endmodule

// File: rtl/locked_counter_v2.sv
// Logic-locked up/down counter: output is the count XORed with a mask derived from the active key.
// Define LOCKED_COUNTER_SAT_EN to make counting saturate instead of wrapping.
module locked_counter_v2
  import locked_counter_pkg::*;
#(
  parameter int                  WIDTH    = LC_WIDTH,
  parameter int                  KEY_SIZE = LC_KEY_SIZE,
  parameter int                  CHUNK    = LC_CHUNK,
  parameter logic [KEY_SIZE-1:0] KEY_GOLD = KEY_SIZE'(LC_KEY_GOLD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             do_incr,
  input  logic             dir,
  input  logic             clear,
  input  logic             key_chunk_valid,
  input  logic [CHUNK-1:0] key_chunk,
  input  logic             key_commit,
  output logic             commit_ack,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (WIDTH < 1 || WIDTH > LC_MAX_WIDTH) begin : g_bad_width
      $error("locked_counter_v2: WIDTH must be 1..32");
    end
    if (CHUNK < 1 || KEY_SIZE < CHUNK || KEY_SIZE > LC_MAX_KEY) begin : g_bad_key_size
      $error("locked_counter_v2: need 1 <= CHUNK <= KEY_SIZE <= 256");
    end
    if (KEY_SIZE % CHUNK != 0) begin : g_bad_chunk
      $error("locked_counter_v2: KEY_SIZE must be a multiple of CHUNK");
    end
  endgenerate

  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = '0;

  logic [KEY_SIZE-1:0]     active_key;
  logic [KEY_SIZE-1:0]     mismatch;
  logic [LC_MAX_WIDTH-1:0] mask_full;
  logic [WIDTH-1:0]        mask;
  logic                    mask_unused;
  logic [WIDTH-1:0]        count;
  logic [WIDTH-1:0]        count_next;

  lc_key_loader #(
    .KEY_SIZE (KEY_SIZE),
    .CHUNK    (CHUNK)
  ) u_key_loader (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_chunk_valid (key_chunk_valid),
    .key_chunk       (key_chunk),
    .key_commit      (key_commit),
    .commit_ack      (commit_ack),
    .active_key      (active_key)
  );

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = ZERO_C;
    end else if (do_incr) begin
      if (dir) begin
`ifdef LOCKED_COUNTER_SAT_EN
        if (count != ZERO_C) begin
          count_next = count - ONE_C;
        end
`else
        count_next = count - ONE_C;
`endif
      end else begin
`ifdef LOCKED_COUNTER_SAT_EN
        if (count != ~ZERO_C) begin
          count_next = count + ONE_C;
        end
`else
        count_next = count + ONE_C;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Mask depends only on the registered active key, so data_out has no input-to-output path.
  assign mismatch    = active_key ^ KEY_GOLD;
  assign mask_full   = lc_expand_mask(LC_MAX_KEY'(mismatch), KEY_SIZE);
  assign mask        = mask_full[WIDTH-1:0];
  assign mask_unused = ^mask_full;
  assign data_out    = count ^ mask;

endmodule

// File: tb/tb_locked_counter_v2.sv
// Scoreboard bench for locked_counter_v2: directed plan sequences followed by randomized traffic.
module tb_locked_counter_v2;

  localparam int             W    = 8;
  localparam int             K    = 16;
  localparam int             C    = 4;
  localparam int             NCH  = K / C;
  localparam logic [K-1:0]   GOLD = 16'hA5C3;
`ifdef LOCKED_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         do_incr = 1'b0;
  logic         dir = 1'b0;
  logic         clear = 1'b0;
  logic         key_chunk_valid = 1'b0;
  logic [C-1:0] key_chunk = '0;
  logic         key_commit = 1'b0;
  logic         commit_ack;
  logic [W-1:0] data_out;

  always #5 clk = ~clk;

  locked_counter_v2 #(
    .WIDTH    (W),
    .KEY_SIZE (K),
    .CHUNK    (C),
    .KEY_GOLD (GOLD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .do_incr         (do_incr),
    .dir             (dir),
    .clear           (clear),
    .key_chunk_valid (key_chunk_valid),
    .key_chunk       (key_chunk),
    .key_commit      (key_commit),
    .commit_ack      (commit_ack),
    .data_out        (data_out)
  );

  int n_total = 0;
  int n_pass  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: count as an integer, key history as a list of beats.
  longint       m_count;
  logic [K-1:0] m_active;
  int           m_beats;
  logic [C-1:0] m_hist[$];
  logic [W-1:0] exp_data_q[$];
  logic         exp_ack_q[$];

  function automatic void model_reset();
    m_count  = 0;
    m_active = '0;
    m_beats  = 0;
    m_hist.delete();
  endfunction

  function automatic logic [K-1:0] model_shadow();
    logic [K-1:0] s = '0;
    foreach (m_hist[i]) s = (s << C) | K'(m_hist[i]);
    return s;
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [K-1:0] mm = m_active ^ GOLD;
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = mm[i % K];
    return W'(m_count) ^ r;
  endfunction

  function automatic void model_step(logic incr, logic d, logic clr, logic kv,
                                     logic [C-1:0] kc, logic kcm);
    longint maxv = (longint'(1) << W) - 1;
    logic   ack;
    if (kv) begin
      m_hist.push_back(kc);
      if (m_hist.size() > NCH) void'(m_hist.pop_front());
      m_beats++;
    end
    ack = kcm && (m_beats >= NCH);
    if (ack) begin
      m_active = model_shadow();
      m_beats  = 0;
    end
    if (clr) m_count = 0;
    else if (incr && !d) m_count = (m_count == maxv) ? (SAT ? maxv : 0) : m_count + 1;
    else if (incr && d)  m_count = (m_count == 0) ? (SAT ? 0 : maxv) : m_count - 1;
    exp_data_q.push_back(model_out());
    exp_ack_q.push_back(ack);
  endfunction

  task automatic drive(input logic incr, input logic d, input logic clr, input logic kv,
                       input logic [C-1:0] kc, input logic kcm);
    @(negedge clk);
    do_incr = incr; dir = d; clear = clr;
    key_chunk_valid = kv; key_chunk = kc; key_commit = kcm;
    model_step(incr, d, clr, kv, kc, kcm);
    @(posedge clk);
    #1;
    do_incr = 1'b0; dir = 1'b0; clear = 1'b0;
    key_chunk_valid = 1'b0; key_chunk = '0; key_commit = 1'b0;
  endtask

  task automatic beat(input logic [C-1:0] kc, input logic kcm);
    drive(1'b0, 1'b0, 1'b0, 1'b1, kc, kcm);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] ed, input logic ea);
    @(negedge clk);
    check({name, "_data"}, data_out, ed);
    check({name, "_ack"}, commit_ack, ea);
  endtask

  task automatic pulse_reset(input int dly);
    @(negedge clk);
    #(dly);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_data", data_out, 8'hC3);
    check("async_rst_ack", commit_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [W-1:0] ed;
    logic         ea;
    #1;
    if (exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      ea = exp_ack_q.pop_front();
      check("sb_data", data_out, ed);
      check("sb_ack", commit_ack, ea);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K-1:0] g;
    int           r;
    model_reset();

    // 1: reset then idle
    pulse_reset(2);
    repeat (3) drive(0, 0, 0, 0, '0, 0);
    check_out("p1_idle", 8'hC3, 1'b0);

    // 2: correct key, then count up
    beat(4'hA, 0); beat(4'h5, 0); beat(4'hC, 0); beat(4'h3, 0);
    drive(0, 0, 0, 0, '0, 1);
    check_out("p2_commit", 8'h00, 1'b1);
    repeat (3) drive(1, 0, 0, 0, '0, 0);
    check_out("p2_count3", 8'h03, 1'b0);

    // 3: boundaries
    drive(0, 0, 1, 0, '0, 0);
    drive(1, 1, 0, 0, '0, 0);
    check_out("p3_down_from0", SAT ? 8'h00 : 8'hFF, 1'b0);
    drive(0, 0, 1, 0, '0, 0);
    repeat (255) drive(1, 0, 0, 0, '0, 0);
    check_out("p3_count_ff", 8'hFF, 1'b0);
    drive(1, 0, 0, 0, '0, 0);
    check_out("p3_up_from_ff", SAT ? 8'hFF : 8'h00, 1'b0);

    // 4: short load rejected, completing beat with commit accepted
    pulse_reset(3);
    beat(4'hA, 0); beat(4'h5, 0); beat(4'hC, 0);
    drive(0, 0, 0, 0, '0, 1);
    check_out("p4_reject", 8'hC3, 1'b0);
    beat(4'h3, 1);
    check_out("p4_accept", 8'h00, 1'b1);

    // 5: wrong key
    drive(0, 0, 1, 0, '0, 0);
    beat(4'hA, 0); beat(4'h5, 0); beat(4'hC, 0); beat(4'h2, 1);
    check_out("p5_wrong_key", 8'h01, 1'b1);
    repeat (2) drive(1, 0, 0, 0, '0, 0);
    check_out("p5_count2", 8'h03, 1'b0);
    drive(1, 0, 1, 0, '0, 0);
    check_out("p5_clear_prio", 8'h01, 1'b0);

    // 6: async reset mid-load and mid-count
    beat(4'hA, 0); beat(4'h5, 0);
    pulse_reset(1);
    beat(4'hC, 0); beat(4'h3, 0);
    drive(0, 0, 0, 0, '0, 1);
    check_out("p6_reject_after_rst", 8'hC3, 1'b0);
    beat(4'hA, 0); beat(4'h5, 0); beat(4'hC, 0); beat(4'h3, 1);
    repeat (5) drive(1, 0, 0, 0, '0, 0);
    check_out("p6_counting", 8'h05, 1'b0);
    pulse_reset(4);

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        pulse_reset($urandom_range(1, 3));
      end else if (r < 10) begin
        g = (r < 7) ? GOLD : K'($urandom);
        for (int b = 0; b < NCH; b++) begin
          drive(1'($urandom), 1'($urandom), 1'b0, 1'b1, g[K-1-C*b -: C],
                (b == NCH - 1) && (r < 5));
        end
        if (r >= 5) drive(0, 0, 0, 0, '0, 1);
      end else begin
        drive(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) == 0), C'($urandom), ($urandom_range(0, 7) == 0));
      end
    end

    for (int i = 0; i < 10 && exp_data_q.size() > 0; i++) @(negedge clk);
    check("drain", exp_data_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/locked_counter_v2.md
Name: locked_counter_v2

Overview:
- Parametrised successor to the current logic-locked counter.
- Width, key size and key-loading granularity are all parameters.
- Adds up/down counting and a synchronous clear.
- The key is loaded as a chunked serial shadow register with a guarded commit. A wrong key scrambles `data_out`.
- Sits between the chip-top pin decode (`ui_in`) and `uo_out`, replacing the fixed 4-bit key register and the locked counter.

Parameters:
- `WIDTH`, 8, counter and output width (1..32).
- `KEY_SIZE`, 16, active key width in bits.
- `CHUNK`, 4, bits per key-load beat. `KEY_SIZE % CHUNK == 0` is required; elaboration error otherwise.
- `KEY_GOLD`, 16'hA5C3, correct key (`KEY_SIZE` bits).

Ports:
- `clk`, in, 1, single clock; all state on rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `do_incr`, in, 1, step the counter this cycle.
- `dir`, in, 1, 0 = count up, 1 = count down.
- `clear`, in, 1, synchronous counter clear.
- `key_chunk_valid`, in, 1, shift `key_chunk` into the shadow key.
- `key_chunk`, in, `CHUNK`, key beat; MSB-first order.
- `key_commit`, in, 1, request copy of shadow key to active key.
- `commit_ack`, out, 1, one-cycle pulse when a commit is accepted.
- `data_out`, out, `WIDTH`, masked counter value.

Behaviour:
- **Reset (async, `rst_n` = 0):**
  - count = 0, shadow = 0, active key = 0, chunk_cnt = 0, `commit_ack` = 0.
  - `data_out` = 0 ^ mask(0), e.g. 8'hC3 with defaults.
  - Reset mid-load discards the partial shadow.
- **Mask:**
  - mismatch = active_key ^ `KEY_GOLD`.
  - mask[i] = mismatch[i % `KEY_SIZE`] for i in 0..`WIDTH`-1.
  - `data_out` = count ^ mask. It is purely a function of registered state (no input-to-output combinational path).
- **Key shift:**
  - On `key_chunk_valid`: shadow <= {shadow[`KEY_SIZE`-`CHUNK`-1:0], `key_chunk`}.
  - chunk_cnt saturates at NCH = `KEY_SIZE`/`CHUNK`.
- **Commit:**
  - Accepted only if chunk_cnt_next == NCH, where chunk_cnt_next includes a same-cycle valid beat.
  - Same-cycle `key_chunk_valid` + `key_commit`: the shift happens first, and the committed key includes the new beat.
  - On accept:
    - active key <= shadow_next, chunk_cnt <= 0.
    - `commit_ack` = 1 in the next cycle; mask changes from that same edge.
    - The shadow is retained.
  - Rejected commit: no state change, no ack.
  - Extra beats beyond NCH keep shifting, so the last NCH beats win.
- **Counter:**
  - Priority: `clear` > `do_incr`.
  - `clear` sets count <= 0.
  - `do_incr` with `dir` = 0: count + 1; with `dir` = 1: count - 1.
  - Modulo 2^`WIDTH` (wrap) by default.
  - Counter and key paths are independent; simultaneous events all take effect in the same cycle.
- **Latency:** one cycle from any input to its effect on `data_out` / `commit_ack`.

Optional Feature:
- `LOCKED_COUNTER_SAT_EN`
  - Defined: counting saturates. Up at all-ones holds; down at 0 holds. `clear` is unaffected.
  - Undefined: modulo wrap as above.
- Key/mask behaviour is identical either way.

Decomposition:
- Package `locked_counter_pkg`:
  - default constants `LC_WIDTH`, `LC_KEY_SIZE`, `LC_CHUNK`, `LC_KEY_GOLD`.
  - function `lc_expand_mask(mismatch)` producing the `WIDTH`-bit mask.
- Sub-module `lc_key_loader`:
  - owns shadow, chunk_cnt, active key and `commit_ack`.
  - exports `active_key`.
- Top-level `locked_counter_v2` holds the counter, mask and output XOR.

Test Plan:
1. Reset, idle 3 cycles -> `data_out` = 8'hC3, `commit_ack` = 0.
2. Beats A,5,C,3 then commit -> `commit_ack` pulse one cycle later, `data_out` = 8'h00. Then 3x `do_incr` (`dir` = 0) -> 8'h03.
3. Correct key, `dir` = 1, 1x `do_incr` from 0 -> 8'hFF (wrap). With `LOCKED_COUNTER_SAT_EN` -> 8'h00. With count = 8'hFF, `dir` = 0, incr -> 8'h00 (wrap) / 8'hFF (sat).
4. Only 3 beats (A,5,C) then commit -> no `commit_ack`, `data_out` still count ^ 8'hC3. Fourth beat 3 together with commit -> ack, `data_out` = count.
5. Wrong key beats A,5,C,2 + commit -> ack, mask = 8'h01. After 2 increments `data_out` = 8'h03. `clear` + `do_incr` same cycle -> 8'h01.
6. `rst_n` low asynchronously mid-load (after 2 beats) and mid-count -> immediate `data_out` = 8'hC3. Subsequent commit after 2 beats is rejected.
